ambilight_switch_poller: RTL and testbench

AMBILIGHT_SWITCH_POLLER -- requirements
Module: ambilight_switch_poller

---
 rtl/ambilight_switch_poller.sv | 212 +++++++++++++++++++++
 tb/tb_ambilight_switch_poller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ambilight_switch_poller.sv
// ambilight_switch_poller
// Periodically reads a switch PIO over an Avalon-MM master port, detects
// changes against the previous sample and queues change events in a small
// FIFO that the CPU drains through a 4-register Avalon-MM slave.
// Optional feature macro: SWITCH_POLLER_IRQ_EN (enables CTRL.IRQ_EN and irq).
//
// Slave handshake: s_read/s_write are single-cycle strobes that are never
// asserted together; read data appears on s_readdata the cycle after s_read
// and is 0 in every other cycle.
module ambilight_switch_poller #(
    parameter int WIDTH      = 18,
    parameter int FIFO_DEPTH = 4,
    parameter int PERIOD_RST = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        irq,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_READ    = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    localparam int          PW           = $clog2(FIFO_DEPTH);
    localparam logic [4:0]  DEPTH_C      = 5'(FIFO_DEPTH);
    localparam logic [23:0] PERIOD_RST_C = 24'(PERIOD_RST);

    logic [1:0]       state_q, state_d;
    logic [23:0]      cnt_q, cnt_d;
    logic [23:0]      period_q;
    logic [23:0]      load_val;
    logic             ctrl_en_q, ctrl_en_d;
    logic             irq_en_q, irq_en_d;
    logic             ovf_q;
    logic             base_valid_q;
    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] sample;
    logic             sample_en;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [4:0]       count_q, count_d;
    logic             push_req, push, pop, ovf_set;
    logic             wr_ctrl, wr_period, wr_status, rd_event;
    logic [31:0]      rdata_d, s_readdata_q;
    logic             irq_q;
    logic             unused_ok;

    assign wr_ctrl   = s_write && (s_address == 2'd0);
    assign wr_period = s_write && (s_address == 2'd1);
    assign wr_status = s_write && (s_address == 2'd3);
    assign rd_event  = s_read  && (s_address == 2'd2);

    // A CTRL write in the current cycle already counts when deciding to stop,
    // so clearing EN in WAIT or CAPTURE parks the FSM on the next edge.
    assign ctrl_en_d = wr_ctrl ? s_writedata[0] : ctrl_en_q;

`ifdef SWITCH_POLLER_IRQ_EN
    assign irq_en_d = wr_ctrl ? s_writedata[1] : irq_en_q;

    // IRQ enable bit of CTRL
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_en_q <= 1'b0;
        else          irq_en_q <= irq_en_d;
    end
`else
    assign irq_en_d = 1'b0;
    assign irq_en_q = 1'b0;
`endif

    // A PERIOD of 0 still waits one cycle so the poll rate never stalls
    assign load_val = (period_q == 24'd0) ? 24'd1 : period_q;
    assign sample   = m_readdata[WIDTH-1:0];

    // Poll sequencer: IDLE -> WAIT (countdown) -> READ -> CAPTURE -> WAIT
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sample_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ctrl_en_q) begin
                    state_d = S_WAIT;
                    cnt_d   = load_val;
                end
            end
            S_WAIT: begin
                if (!ctrl_en_d)              state_d = S_IDLE;
                else if (cnt_q <= 24'd1)     state_d = S_READ;
                else                         cnt_d   = cnt_q - 24'd1;
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            default: begin
                // Read data lands this cycle; it is only used if still enabled
                if (ctrl_en_d) begin
                    sample_en = 1'b1;
                    state_d   = S_WAIT;
                    cnt_d     = load_val;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // FSM, counter and control register state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 24'd0;
            ctrl_en_q <= 1'b0;
            period_q  <= PERIOD_RST_C;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_en_q <= ctrl_en_d;
            if (wr_period) period_q <= s_writedata[23:0];
        end
    end

    // Change detection; the first sample after enabling only sets the baseline.
    // A pop frees a slot before the push is considered, so full+pop+push works.
    assign push_req = sample_en && base_valid_q && (sample != last_q);
    assign pop      = rd_event && (count_q != 5'd0);
    assign push     = push_req && ((count_q != DEPTH_C) || pop);
    assign ovf_set  = push_req && !push;
    assign count_d  = count_q + {4'd0, push} - {4'd0, pop};

    // Baseline tracking, FIFO pointers/occupancy and sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_valid_q <= 1'b0;
            last_q       <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= 5'd0;
            ovf_q        <= 1'b0;
        end else begin
            if (sample_en) begin
                base_valid_q <= 1'b1;
                last_q       <= sample;
            end else if (state_d == S_IDLE) begin
                base_valid_q <= 1'b0;
            end
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            if (ovf_set)                        ovf_q <= 1'b1;
            else if (wr_status && s_writedata[8]) ovf_q <= 1'b0;
        end
    end

    // FIFO storage; contents are meaningless until counted, so no reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= sample;
    end

    // Slave read mux; idle cycles return 0
    always_comb begin
        rdata_d = '0;
        if (s_read) begin
            case (s_address)
                2'd0: begin
                    rdata_d[0] = ctrl_en_q;
                    rdata_d[1] = irq_en_q;
                end
                2'd1: rdata_d[23:0] = period_q;
                2'd2: begin
                    if (count_q != 5'd0) begin
                        rdata_d[31]        = 1'b1;
                        rdata_d[WIDTH-1:0] = mem_q[rd_ptr_q];
                    end
                end
                default: begin
                    rdata_d[4:0] = count_q;
                    rdata_d[8]   = ovf_q;
                end
            endcase
        end
    end

    // Registered read data and interrupt (irq tracks the post-update COUNT)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_readdata_q <= 32'd0;
            irq_q        <= 1'b0;
        end else begin
            s_readdata_q <= rdata_d;
            irq_q        <= irq_en_d && (count_d != 5'd0);
        end
    end

    assign s_readdata  = s_readdata_q;
    assign irq         = irq_q;
    assign m_read      = (state_q == S_READ);
    assign m_address   = 2'b00;
    assign dbg_state_o = state_q;

    assign unused_ok = ^{s_writedata[31:24], m_readdata[31:WIDTH]};

endmodule

// File: tb/tb_ambilight_switch_poller.sv
// Directed bench for ambilight_switch_poller (WIDTH=18, FIFO_DEPTH=4).
module tb_ambilight_switch_poller;

    logic        clk;
    logic        reset_n;
    logic [1:0]  m_address;
    logic        m_read;
    logic [31:0] m_readdata = 32'hDEAD_BEEF;
    logic [1:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        irq;
    logic [1:0]  dbg_state;

    logic [17:0] sw;
    int          n_vec = 0;
    int          n_err = 0;

    ambilight_switch_poller #(
        .WIDTH(18), .FIFO_DEPTH(4), .PERIOD_RST(50000)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_readdata(s_readdata),
        .irq(irq), .dbg_state_o(dbg_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // switch PIO: read latency 1, garbage when not being read
    always @(posedge clk) m_readdata <= m_read ? {14'd0, sw} : 32'hDEAD_BEEF;

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        s_address   = a;
        s_writedata = d;
        s_write     = 1'b1;
        tick();
        s_write     = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        s_address = a;
        s_read    = 1'b1;
        tick();
        s_read    = 1'b0;
        d         = s_readdata;
    endtask

    // returns in the READ cycle
    task automatic wait_read();
        int n;
        n = 0;
        while (m_read !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("m_read_seen", {31'd0, m_read}, 32'd1);
    endtask

    // called in a READ cycle; cycles until the next READ
    task automatic measure_gap(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (m_read !== 1'b1 && n < 100);
    endtask

    // READ -> CAPTURE -> first cycle where the capture result is visible
    task automatic finish_capture();
        tick();
        tick();
    endtask

    initial begin
        logic [31:0] d;
        int gap;

        reset_n     = 1'b0;
        s_address   = 2'd0;
        s_read      = 1'b0;
        s_write     = 1'b0;
        s_writedata = 32'd0;
        sw          = 18'h00005;
        repeat (3) tick();
        check("rst_m_read",     {31'd0, m_read},  32'd0);
        check("rst_m_address",  {30'd0, m_address}, 32'd0);
        check("rst_s_readdata", s_readdata,       32'd0);
        check("rst_irq",        {31'd0, irq},     32'd0);
        check("rst_state",      {30'd0, dbg_state}, 32'd0);
        reset_n = 1'b1;
        tick();
        cpu_read(2'd1, d); check("rst_period", d, 32'd50000);
        cpu_read(2'd0, d); check("rst_ctrl",   d, 32'd0);
        cpu_read(2'd3, d); check("rst_status", d, 32'd0);
        cpu_read(2'd2, d); check("rst_event_empty", d, 32'd0);

        // steady polling, PERIOD=10 -> 12-cycle spacing, constant switches
        cpu_write(2'd1, 32'd10);
        cpu_write(2'd0, 32'd1);
        wait_read();
        check("m_address_in_read", {30'd0, m_address}, 32'd0);
        measure_gap(gap); check("gap_p10_a", gap, 32'd12);
        measure_gap(gap); check("gap_p10_b", gap, 32'd12);
        tick();
        cpu_read(2'd3, d); check("const_sw_no_event", d, 32'd0);

        // a change after the baseline produces one event
        sw = 18'h20001;
        wait_read();
        finish_capture();
        cpu_read(2'd3, d); check("change_count1", d, 32'd1);
        cpu_read(2'd2, d); check("change_event",  d, 32'h8002_0001);
        cpu_read(2'd3, d); check("change_drained", d, 32'd0);

        // five changes, no pops -> full and overflow
        for (int i = 1; i <= 5; i++) begin
            sw = 18'(i);
            wait_read();
            finish_capture();
        end
        cpu_read(2'd3, d); check("overflow_status", d, 32'h0000_0104);
        cpu_write(2'd3, 32'h100);
        cpu_read(2'd3, d); check("ovf_cleared", d, 32'h0000_0004);

        // full FIFO, pop lands in the CAPTURE cycle of a changed sample
        sw = 18'h6;
        wait_read();
        tick();
        cpu_read(2'd2, d); check("pop_in_capture", d, 32'h8000_0001);
        cpu_read(2'd3, d); check("pop_push_status", d, 32'h0000_0004);
        cpu_read(2'd2, d); check("drain_2", d, 32'h8000_0002);
        cpu_read(2'd2, d); check("drain_3", d, 32'h8000_0003);
        cpu_read(2'd2, d); check("drain_4", d, 32'h8000_0004);
        cpu_read(2'd2, d); check("drain_6", d, 32'h8000_0006);
        cpu_read(2'd2, d); check("drain_empty", d, 32'd0);
        cpu_read(2'd3, d); check("drain_status", d, 32'd0);

        // interrupt
        cpu_write(2'd0, 32'd3);
`ifdef SWITCH_POLLER_IRQ_EN
        cpu_read(2'd0, d); check("ctrl_irq_en_rw", d, 32'd3);
        sw = 18'h7;
        wait_read();
        finish_capture();
        check("irq_raised", {31'd0, irq}, 32'd1);
        cpu_read(2'd2, d); check("irq_event", d, 32'h8000_0007);
        check("irq_dropped", {31'd0, irq}, 32'd0);
`else
        cpu_read(2'd0, d); check("ctrl_irq_en_ro", d, 32'd1);
        sw = 18'h7;
        wait_read();
        finish_capture();
        check("irq_tied_low", {31'd0, irq}, 32'd0);
        cpu_read(2'd2, d); check("irq_event", d, 32'h8000_0007);
`endif
        cpu_read(2'd2, d); check("irq_empty_event", d, 32'd0);

        // EN cleared during READ: read completes, sample discarded, IDLE
        sw = 18'h8;
        wait_read();
        cpu_write(2'd0, 32'd0);
        check("dis_in_capture", {30'd0, dbg_state}, 32'd3);
        tick();
        check("dis_idle", {30'd0, dbg_state}, 32'd0);
        cpu_read(2'd3, d); check("dis_no_event", d, 32'd0);
        cpu_write(2'd0, 32'd1);
        wait_read();
        finish_capture();
        cpu_read(2'd3, d); check("reen_baseline", d, 32'd0);
        sw = 18'h9;
        wait_read();
        finish_capture();
        cpu_read(2'd3, d); check("reen_count", d, 32'd1);
        cpu_read(2'd2, d); check("reen_event", d, 32'h8000_0009);

        // reset in the middle of a read
        sw = 18'hA;
        wait_read();
        reset_n = 1'b0;
        #1;
        check("rst_mid_read_m_read", {31'd0, m_read}, 32'd0);
        check("rst_mid_read_state",  {30'd0, dbg_state}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        cpu_read(2'd3, d); check("rst_mid_status", d, 32'd0);
        cpu_read(2'd0, d); check("rst_mid_ctrl",   d, 32'd0);
        cpu_read(2'd1, d); check("rst_mid_period", d, 32'd50000);

        // PERIOD=0 behaves as 1 -> 3-cycle spacing
        cpu_write(2'd1, 32'd0);
        cpu_write(2'd0, 32'd1);
        wait_read();
        measure_gap(gap); check("gap_p0_a", gap, 32'd3);
        measure_gap(gap); check("gap_p0_b", gap, 32'd3);
        tick();
        cpu_read(2'd3, d); check("p0_no_event", d, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
